// File: rtl/display_scan_mux4.sv
// Four-digit multiplexed 7-segment scanner: synchronised refresh steps the digit,
// an all-off gap precedes each new anode, and loads are double-buffered per frame.
module display_scan_mux4 #(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        refresh,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    typedef enum logic {SHOW, GAP} state_t;

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    state_t      state_q;
    logic        sync1_q, sync2_q, hist_q;
    logic        step;
    logic [1:0]  idx_q;
    logic [3:0]  gap_cnt_q;
    logic [15:0] shadow_val_q, active_val_q;
    logic [3:0]  shadow_dp_q, active_dp_q;
    logic        pending_q;
    logic [3:0]  an_q;
    logic [6:0]  seg_q;
    logic        dp_q;
    logic        frame_done_q;

    logic [3:0]  digit_d;
    logic [3:0]  zero_above;
    logic        blank_d;
    logic [6:0]  seg_d;
    logic        dp_d;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_ff @(posedge clock_in) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= refresh;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign step = sync2_q & ~hist_q;

    // Decode the digit at the current index; in GAP the index already points at the next digit.
    always_comb begin
        digit_d       = active_val_q[{idx_q, 2'b00} +: 4];
        zero_above[3] = (active_val_q[15:12] == 4'h0);
        zero_above[2] = zero_above[3] && (active_val_q[11:8] == 4'h0);
        zero_above[1] = zero_above[2] && (active_val_q[7:4] == 4'h0);
        zero_above[0] = 1'b0;
        blank_d       = blank_lz && zero_above[idx_q];
        seg_d         = blank_d ? '1 : hex_to_seg(digit_d);
        dp_d          = ~active_dp_q[idx_q];
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q      <= SHOW;
            idx_q        <= '0;
            gap_cnt_q    <= '0;
            shadow_val_q <= '0;
            active_val_q <= '0;
            shadow_dp_q  <= '0;
            active_dp_q  <= '0;
            pending_q    <= 1'b0;
            an_q         <= '1;
            seg_q        <= '1;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (load) begin
                shadow_val_q <= value;
                shadow_dp_q  <= dp_in;
                pending_q    <= 1'b1;
            end
            case (state_q)
                SHOW: begin
                    if (step) begin
                        state_q   <= GAP;
                        idx_q     <= idx_q + 2'd1;
                        gap_cnt_q <= GAP_LOAD;
                        an_q      <= '1;
                        seg_q     <= '1;
                        dp_q      <= 1'b1;
                        // Frame boundary: swap uses the pre-load shadow; a coincident load stays pending.
                        if (idx_q == 2'd3) begin
                            frame_done_q <= 1'b1;
                            if (pending_q) begin
                                active_val_q <= shadow_val_q;
                                active_dp_q  <= shadow_dp_q;
                            end
                            pending_q <= load;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q == 4'd0) begin
                        state_q <= SHOW;
                        an_q    <= ~(4'b0001 << idx_q);
                        seg_q   <= seg_d;
                        dp_q    <= dp_d;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 4'd1;
                    end
                end
                default: state_q <= SHOW;
            endcase
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule
